// File: rtl/sd_arb_pkg.sv
// ============================================================================
// Module   : sd_arb_pkg
// Purpose  : Shared types and constants for the SD block-request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd_arb_pkg;

  localparam int SD_ARB_CLIENTS = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACKWAIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_XFER    = 3'd3,
    ST_DONE    = 3'd4
  } sd_arb_state_e;

  typedef enum logic {
    SD_OP_RD = 1'b0,
    SD_OP_WR = 1'b1
  } sd_op_e;

endpackage

`default_nettype wire

// File: rtl/sd_arb_rr.sv
// ============================================================================
// Module   : sd_arb_rr
// Purpose  : Two-input round-robin picker; the client not served last wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_arb_rr
  import sd_arb_pkg::*;
(
  input  logic [SD_ARB_CLIENTS-1:0] eligible,
  input  logic                      rr_last,
  output logic [SD_ARB_CLIENTS-1:0] pick,
  output logic                      valid
);

  always_comb begin
    pick = '0;
    case (eligible)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = rr_last ? 2'b01 : 2'b10;
      default: pick = '0;
    endcase
  end

  assign valid = |eligible;

endmodule

`default_nettype wire

// File: rtl/sd_req_arbiter.sv
// ============================================================================
// Module   : sd_req_arbiter
// Purpose  : Round-robin sharing of the SD block-request channel between
//            two disk clients, following the sd_ack handshake.
// Options  : SD_ARB_TIMEOUT_EN - abort a request not acked within TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 10_000_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [31:0] c0_lba,
  input  logic [31:0] c1_lba,
  input  logic        c0_rd,
  input  logic        c1_rd,
  input  logic        c0_wr,
  input  logic        c1_wr,
  output logic        c0_done,
  output logic        c1_done,
  output logic        c0_err,
  output logic        c1_err,
  output logic        c0_buff_wr,
  output logic        c1_buff_wr,
  input  logic [7:0]  c0_buff_din,
  input  logic [7:0]  c1_buff_din,
  output logic [31:0] sd_lba,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic [1:0]  grant
);

  sd_arb_state_e state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    sd_rd_q, sd_rd_d;
  logic [1:0]    sd_wr_q, sd_wr_d;
  logic [1:0]    done_q, done_d;
  logic [31:0]   lba_q, lba_d;
  logic          rr_last_q, rr_last_d;

  logic [1:0]    eligible;
  logic [1:0]    pick;
  logic          pick_valid;
  sd_op_e        op_sel;
  logic [31:0]   lba_sel;

`ifdef SD_ARB_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]  err_q, err_d;
`endif

  assign eligible = {c1_rd | c1_wr, c0_rd | c0_wr};

  sd_arb_rr u_rr (
    .eligible (eligible),
    .rr_last  (rr_last_q),
    .pick     (pick),
    .valid    (pick_valid)
  );

  // Read wins over write when a client raises both levels at once.
  always_comb begin
    if (pick[1]) begin
      op_sel  = c1_rd ? SD_OP_RD : SD_OP_WR;
      lba_sel = c1_lba;
    end else begin
      op_sel  = c0_rd ? SD_OP_RD : SD_OP_WR;
      lba_sel = c0_lba;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    lba_d     = lba_q;
    rr_last_d = rr_last_q;
    done_d    = '0;
`ifdef SD_ARB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    err_d     = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sd_ack) begin
          state_d = ST_ACKWAIT;
        end else if (pick_valid) begin
          grant_d = pick;
          lba_d   = lba_sel;
          if (op_sel == SD_OP_RD) sd_rd_d = pick;
          else                    sd_wr_d = pick;
`ifdef SD_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
          state_d = ST_REQ;
        end
      end
      ST_ACKWAIT: begin
        if (!sd_ack) state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (sd_ack) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
          state_d = ST_XFER;
        end
`ifdef SD_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          sd_rd_d   = '0;
          sd_wr_d   = '0;
          err_d     = grant_q;
          rr_last_d = grant_q[1];
          grant_d   = '0;
          state_d   = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
`endif
      end
      ST_XFER: begin
        if (!sd_ack) begin
          done_d  = grant_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        rr_last_d = grant_q[1];
        grant_d   = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      sd_rd_q   <= '0;
      sd_wr_q   <= '0;
      lba_q     <= '0;
      done_q    <= '0;
      rr_last_q <= 1'b1;
`ifdef SD_ARB_TIMEOUT_EN
      tmo_cnt_q <= '0;
      err_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      lba_q     <= lba_d;
      done_q    <= done_d;
      rr_last_q <= rr_last_d;
`ifdef SD_ARB_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign sd_lba  = lba_q;
  assign sd_rd   = sd_rd_q;
  assign sd_wr   = sd_wr_q;
  assign grant   = grant_q;
  assign c0_done = done_q[0];
  assign c1_done = done_q[1];

`ifdef SD_ARB_TIMEOUT_EN
  assign c0_err = err_q[0];
  assign c1_err = err_q[1];
`else
  assign c0_err = 1'b0;
  assign c1_err = 1'b0;
`endif

  // Buffer strobes outside XFER never reach a client.
  assign c0_buff_wr  = sd_buff_wr & (state_q == ST_XFER) & grant_q[0];
  assign c1_buff_wr  = sd_buff_wr & (state_q == ST_XFER) & grant_q[1];
  assign sd_buff_din = grant_q[1] ? c1_buff_din :
                       grant_q[0] ? c0_buff_din : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_sd_req_arbiter.sv
// ============================================================================
// Module   : tb_sd_req_arbiter
// Purpose  : Self-checking bench for sd_req_arbiter with a behavioural model
//            of the I/O block and the round-robin ownership rule.
// Options  : SD_ARB_TIMEOUT_EN - selects the timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd_req_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [31:0] c0_lba = '0, c1_lba = '0;
  logic        c0_rd = 0, c1_rd = 0, c0_wr = 0, c1_wr = 0;
  logic        c0_done, c1_done, c0_err, c1_err, c0_buff_wr, c1_buff_wr;
  logic [7:0]  c0_buff_din = '0, c1_buff_din = '0;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr, grant;
  logic        sd_ack = 1'b0, sd_buff_wr = 1'b0;
  logic [7:0]  sd_buff_din;

  int n_checks = 0;
  int n_fail   = 0;
  int m_last   = 1;   // last client served, as seen by the reference model
  int onehot_viol = 0;
  int err_seen    = 0;

  sd_req_arbiter #(.TIMEOUT(100)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .c0_lba(c0_lba), .c1_lba(c1_lba),
    .c0_rd(c0_rd), .c1_rd(c1_rd), .c0_wr(c0_wr), .c1_wr(c1_wr),
    .c0_done(c0_done), .c1_done(c1_done), .c0_err(c0_err), .c1_err(c1_err),
    .c0_buff_wr(c0_buff_wr), .c1_buff_wr(c1_buff_wr),
    .c0_buff_din(c0_buff_din), .c1_buff_din(c1_buff_din),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .grant(grant)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (!reset && $countones({sd_wr, sd_rd}) > 1) onehot_viol++;
    if (c0_err === 1'b1 || c1_err === 1'b1) err_seen++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Whoever asks alone wins; on contention the client not served last wins.
  function automatic int model_pick(input bit e0, input bit e1);
    if (e0 && e1) return (m_last == 0) ? 1 : 0;
    return e1 ? 1 : 0;
  endfunction

  task automatic clear_req(input int c, input bit [1:0] mask);
    if (c == 0) begin
      if (mask[0]) c0_rd = 1'b0;
      if (mask[1]) c0_wr = 1'b0;
    end else begin
      if (mask[0]) c1_rd = 1'b0;
      if (mask[1]) c1_wr = 1'b0;
    end
  endtask

  task automatic do_reset();
    c0_rd = 0; c1_rd = 0; c0_wr = 0; c1_wr = 0;
    sd_ack = 0; sd_buff_wr = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_last = 1;
  endtask

  // One full transaction as seen by the I/O block; caller has set the request
  // levels during the current (IDLE) cycle.
  task automatic xact(input int c, input bit is_wr, input logic [31:0] lba,
                      input int dly, input int nstb, input bit drop_early,
                      input bit [1:0] drop_done);
    logic [1:0] oh, req_bits;
    logic [7:0] d0, d1;
    int hi, n0, n1;
    oh = (c == 0) ? 2'b01 : 2'b10;
    step();
    n_checks++;
    if (grant !== oh) begin
      n_fail++; $display("FAIL grant: got %b expected %b", grant, oh);
    end
    n_checks++;
    if (sd_lba !== lba) begin
      n_fail++; $display("FAIL sd_lba: got %h expected %h", sd_lba, lba);
    end
    n_checks++;
    if ({sd_wr, sd_rd} !== (is_wr ? {oh, 2'b00} : {2'b00, oh})) begin
      n_fail++; $display("FAIL req_bits: got wr=%b rd=%b expected %s on %b",
                         sd_wr, sd_rd, is_wr ? "wr" : "rd", oh);
    end
    if (drop_early) clear_req(c, 2'b11);
    if (c == 0) c0_lba = ~lba; else c1_lba = ~lba;
    hi = 1;
    for (int i = 0; i < dly; i++) begin
      step();
      req_bits = is_wr ? sd_wr : sd_rd;
      if ((req_bits & oh) != 2'b00) hi++;
    end
    sd_ack = 1'b1;
    step();
    n_checks++;
    if ({sd_wr, sd_rd} !== 4'b0000) begin
      n_fail++; $display("FAIL req_clear: got wr=%b rd=%b expected 0", sd_wr, sd_rd);
    end
    n_checks++;
    if (hi != dly + 1) begin
      n_fail++; $display("FAIL req_cycles: got %0d expected %0d", hi, dly + 1);
    end
    n_checks++;
    if (sd_lba !== lba) begin
      n_fail++; $display("FAIL lba_hold: got %h expected %h", sd_lba, lba);
    end
    n0 = 0; n1 = 0;
    for (int i = 0; i < nstb; i++) begin
      d0 = 8'($urandom); d1 = 8'($urandom);
      c0_buff_din = d0; c1_buff_din = d1; sd_buff_wr = 1'b1;
      #1;
      n0 += int'(c0_buff_wr); n1 += int'(c1_buff_wr);
      n_checks++;
      if (sd_buff_din !== ((c == 0) ? d0 : d1)) begin
        n_fail++; $display("FAIL buff_din: got %h expected %h", sd_buff_din, (c == 0) ? d0 : d1);
      end
      step();
    end
    sd_buff_wr = 1'b0; sd_ack = 1'b0;
    step();
    n_checks++;
    if ({c1_done, c0_done} !== oh) begin
      n_fail++; $display("FAIL done_pulse: got %b expected %b", {c1_done, c0_done}, oh);
    end
    sd_buff_wr = 1'b1;
    #1;
    n_checks++;
    if ({c1_buff_wr, c0_buff_wr} !== 2'b00) begin
      n_fail++; $display("FAIL stray_buff_wr: got %b expected 00", {c1_buff_wr, c0_buff_wr});
    end
    sd_buff_wr = 1'b0;
    n_checks++;
    if (n0 != ((c == 0) ? nstb : 0) || n1 != ((c == 1) ? nstb : 0)) begin
      n_fail++; $display("FAIL strobe_count: got c0=%0d c1=%0d expected %0d to client %0d",
                         n0, n1, nstb, c);
    end
    if (c == 0) c0_lba = lba; else c1_lba = lba;
    clear_req(c, drop_done);
    step();
    n_checks++;
    if ({c1_done, c0_done, grant} !== 4'b0000) begin
      n_fail++; $display("FAIL idle_after_done: got done=%b grant=%b expected 0",
                         {c1_done, c0_done}, grant);
    end
    n_checks++;
    if (sd_buff_din !== 8'h00) begin
      n_fail++; $display("FAIL idle_buff_din: got %h expected 00", sd_buff_din);
    end
    m_last = c;
  endtask

  task automatic test_reset();
    c0_rd = 1'b1; c1_wr = 1'b1; c0_lba = 32'hDEADBEEF;
    reset = 1'b1;
    step(); step();
    n_checks++;
    if (grant !== 2'b00 || sd_rd !== 2'b00 || sd_wr !== 2'b00) begin
      n_fail++; $display("FAIL reset_req: got grant=%b rd=%b wr=%b expected 0", grant, sd_rd, sd_wr);
    end
    n_checks++;
    if (sd_lba !== 32'h0) begin
      n_fail++; $display("FAIL reset_lba: got %h expected 0", sd_lba);
    end
    n_checks++;
    if ({c1_done, c0_done, c1_err, c0_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 0", {c1_done, c0_done, c1_err, c0_err});
    end
    n_checks++;
    if (sd_buff_din !== 8'h00) begin
      n_fail++; $display("FAIL reset_buff_din: got %h expected 00", sd_buff_din);
    end
    c0_rd = 1'b0; c1_wr = 1'b0; c0_lba = '0;
    reset = 1'b0;
    m_last = 1;
    step();
  endtask

  task automatic test_single_read();
    logic [31:0] l;
    c0_lba = 32'h0000_1234; c0_rd = 1'b1;
    xact(model_pick(1, 0), 1'b0, 32'h0000_1234, 3, 512, 1'b1, 2'b11);
    for (int k = 0; k < 6; k++) begin
      int c;
      bit w;
      c = int'($urandom_range(1, 0));
      w = 1'($urandom);
      l = $urandom;
      if (c == 0) begin c0_lba = l; c0_rd = !w; c0_wr = w; end
      else        begin c1_lba = l; c1_rd = !w; c1_wr = w; end
      xact(model_pick(c == 0, c == 1), w, l, int'($urandom_range(4, 0)),
           int'($urandom_range(8, 0)), 1'($urandom), 2'b11);
    end
  endtask

  task automatic test_contention();
    logic [31:0] l0;
    do_reset();
    l0 = $urandom;
    c0_lba = l0; c1_lba = 32'h55;
    c0_rd = 1'b1; c1_wr = 1'b1;
    xact(model_pick(1, 1), 1'b0, l0, 2, 4, 1'b0, 2'b11);
    xact(model_pick(0, 1), 1'b1, 32'h55, 2, 8, 1'b0, 2'b11);
  endtask

  task automatic test_fairness();
    int c;
    bit e0, e1;
    logic [31:0] l0, l1;
    do_reset();
    l0 = $urandom; l1 = $urandom;
    c0_lba = l0; c1_lba = l1;
    c0_rd = 1'b1; c1_wr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      c = model_pick(1, 1);
      xact(c, c == 1, (c == 0) ? l0 : l1, int'($urandom_range(3, 0)),
           int'($urandom_range(5, 0)), 1'b0, 2'b00);
    end
    for (int k = 0; k < 10; k++) begin
      e0 = 1'($urandom); e1 = 1'($urandom);
      if (!e0 && !e1) e0 = 1'b1;
      l0 = $urandom; l1 = $urandom;
      c0_lba = l0; c1_lba = l1;
      c0_rd = e0 & 1'($urandom); c0_wr = e0 & !c0_rd;
      c1_rd = e1 & 1'($urandom); c1_wr = e1 & !c1_rd;
      if (e0 && 1'($urandom)) begin c0_rd = 1'b1; c0_wr = 1'b1; end
      c = model_pick(e0, e1);
      xact(c, (c == 0) ? !c0_rd : !c1_rd, (c == 0) ? l0 : l1,
           int'($urandom_range(3, 0)), int'($urandom_range(5, 0)), 1'b0, 2'b00);
    end
    c0_rd = 0; c0_wr = 0; c1_rd = 0; c1_wr = 0;
    step();
  endtask

  task automatic test_dual_op();
    logic [31:0] l;
    l = $urandom;
    c0_lba = l; c0_rd = 1'b1; c0_wr = 1'b1;
    xact(model_pick(1, 0), 1'b0, l, 1, 2, 1'b0, 2'b01);
    xact(model_pick(1, 0), 1'b1, l, 2, 2, 1'b0, 2'b11);
  endtask

  task automatic test_reset_mid_xfer();
    logic [31:0] l;
    l = $urandom | 32'h1;
    c1_lba = l; c1_rd = 1'b1;
    step();
    n_checks++;
    if (grant !== 2'b10) begin
      n_fail++; $display("FAIL rst_pre_grant: got %b expected 10", grant);
    end
    sd_ack = 1'b1;
    step();
    sd_buff_wr = 1'b1;
    #1;
    n_checks++;
    if (c1_buff_wr !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_strobe: got %b expected 1", c1_buff_wr);
    end
    sd_buff_wr = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_last = 1;
    n_checks++;
    if (grant !== 2'b00 || {sd_wr, sd_rd} !== 4'b0 || sd_lba !== 32'h0 ||
        {c1_done, c0_done} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_outputs: got grant=%b req=%b lba=%h done=%b expected 0",
                         grant, {sd_wr, sd_rd}, sd_lba, {c1_done, c0_done});
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (grant !== 2'b00 || {sd_wr, sd_rd} !== 4'b0) begin
        n_fail++; $display("FAIL ackwait_hold: got grant=%b req=%b expected 0", grant, {sd_wr, sd_rd});
      end
      sd_buff_wr = 1'b1;
      #1;
      n_checks++;
      if ({c1_buff_wr, c0_buff_wr} !== 2'b00) begin
        n_fail++; $display("FAIL ackwait_strobe: got %b expected 00", {c1_buff_wr, c0_buff_wr});
      end
      sd_buff_wr = 1'b0;
    end
    sd_ack = 1'b0;
    step();
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL ackwait_exit: got %b expected 00", grant);
    end
    xact(model_pick(0, 1), 1'b0, l, 1, 3, 1'b0, 2'b11);
  endtask

`ifdef SD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int hi, errs, dones;
    bit dropped;
    c0_lba = $urandom; c0_rd = 1'b1;
    step();
    n_checks++;
    if (sd_rd !== 2'b01) begin
      n_fail++; $display("FAIL tmo_req: got %b expected 01", sd_rd);
    end
    hi = 1; errs = 0; dones = 0; dropped = 1'b0;
    for (int i = 0; i < 200 && !dropped; i++) begin
      step();
      errs += int'(c0_err); dones += int'(c0_done);
      if (sd_rd[0]) hi++;
      else begin
        dropped = 1'b1;
        c0_rd = 1'b0;
        n_checks++;
        if (c0_err !== 1'b1) begin
          n_fail++; $display("FAIL tmo_err_edge: got %b expected 1", c0_err);
        end
      end
    end
    c0_rd = 1'b0;
    n_checks++;
    if (!dropped || hi != 100) begin
      n_fail++; $display("FAIL tmo_drop: got dropped=%0d after %0d cycles expected 100", dropped, hi);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      errs += int'(c0_err); dones += int'(c0_done);
    end
    n_checks++;
    if (errs != 1 || dones != 0 || grant !== 2'b00) begin
      n_fail++; $display("FAIL tmo_pulses: got err=%0d done=%0d grant=%b expected 1,0,00",
                         errs, dones, grant);
    end
    m_last = 0;
  endtask
`else
  task automatic test_no_timeout();
    logic [31:0] l;
    l = $urandom;
    c0_lba = l; c0_rd = 1'b1;
    xact(model_pick(1, 0), 1'b0, l, 150, 2, 1'b0, 2'b11);
    n_checks++;
    if (err_seen != 0) begin
      n_fail++; $display("FAIL err_tied: got %0d err pulses expected 0", err_seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_fairness();
    test_dual_op();
    test_reset_mid_xfer();
`ifdef SD_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    n_checks++;
    if (onehot_viol != 0) begin
      n_fail++; $display("FAIL req_onehot: got %0d violating cycles expected 0", onehot_viol);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
